// File: rtl/mania_pkg.sv
// Shared definitions for the mania note renderer.
//   Screen geometry (640x480), playfield/lane geometry, judgement constants,
//   lane colour table, note slot type and judgement helper functions.
// Optional feature macro used by importers: MANIA_AUTOPLAY_EN.
package mania_pkg;

    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned SCREEN_H       = 480;
    localparam int unsigned LANES          = 4;
    localparam int unsigned NOTES_PER_LANE = 8;
    localparam int unsigned LANE_X0        = 160;
    localparam int unsigned LANE_W         = 80;
    localparam int unsigned NOTE_H         = 16;
    localparam int unsigned HIT_ROW        = 420;
    localparam int unsigned HIT_WIN        = 24;
    localparam int unsigned SCROLL_STEP    = 2;

    localparam int unsigned PTR_W = $clog2(NOTES_PER_LANE);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [11:0] COL_BG       = 12'h000;
    localparam logic [11:0] COL_HIT_LINE = 12'hFFF;
    localparam logic [11:0] COL_TINT     = 12'h223;

    typedef struct packed {
        logic       valid;
        logic [8:0] y;
    } note_slot_t;

    function automatic logic [11:0] lane_colour(input logic [1:0] lane);
        case (lane)
            2'd0:    return 12'hF44;
            2'd1:    return 12'h4F4;
            2'd2:    return 12'h48F;
            default: return 12'hFF4;
        endcase
    endfunction

    // |y + NOTE_H/2 - HIT_ROW| <= HIT_WIN, evaluated unsigned on the centre row
    function automatic logic in_hit_window(input logic [8:0] y);
        logic [9:0] centre;
        centre = {1'b0, y} + 10'(NOTE_H / 2);
        return (centre >= 10'(HIT_ROW - HIT_WIN)) && (centre <= 10'(HIT_ROW + HIT_WIN));
    endfunction

    function automatic logic autoplay_due(input logic [8:0] y);
        logic [9:0] centre;
        centre = {1'b0, y} + 10'(NOTE_H / 2);
        return centre >= 10'(HIT_ROW);
    endfunction

    function automatic logic covers_row(input logic [8:0] y, input logic [8:0] row);
        return ({1'b0, row} >= {1'b0, y}) && ({1'b0, row} < ({1'b0, y} + 10'(NOTE_H)));
    endfunction

endpackage

// File: rtl/mania_lane_fifo.sv
// One lane's note ring buffer.
//   clk, rst     : clock, synchronous active-high reset (empties the lane)
//   frame_tick   : scroll all notes by SCROLL_STEP, remove head that falls off
//   push         : append a note at y=0 at the tail
//   pop_hit      : remove the head as a hit (not scrolled, not missed)
//   row          : current pixel row for body coverage
//   ready        : lane has a free slot
//   head_valid   : lane non-empty; head_y is the oldest note's row
//   miss         : head leaves the screen on this tick (pop this cycle)
//   covered      : some note body covers row
module mania_lane_fifo
    import mania_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       push,
    input  logic       pop_hit,
    input  logic [8:0] row,
    output logic       ready,
    output logic       head_valid,
    output logic [8:0] head_y,
    output logic       miss,
    output logic       covered
);

    note_slot_t       slots [NOTES_PER_LANE];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [9:0]       next_head_y;
    logic             pop;

    assign ready       = count < CNT_W'(NOTES_PER_LANE);
    assign head_valid  = count != '0;
    assign head_y      = slots[head_ptr].y;
    assign next_head_y = {1'b0, head_y} + 10'(SCROLL_STEP);
    assign miss        = frame_tick & head_valid & ~pop_hit & (next_head_y >= 10'(SCREEN_H));
    assign pop         = pop_hit | miss;

    always_comb begin
        covered = 1'b0;
        for (int unsigned i = 0; i < NOTES_PER_LANE; i++) begin
            if (slots[i].valid && covers_row(slots[i].y, row)) covered = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots    <= '{default: '0};
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            for (int unsigned i = 0; i < NOTES_PER_LANE; i++) begin
                if (frame_tick && slots[i].valid && !(pop_hit && (PTR_W'(i) == head_ptr)))
                    slots[i].y <= slots[i].y + 9'(SCROLL_STEP);
            end
            if (pop) begin
                slots[head_ptr].valid <= 1'b0;
                head_ptr              <= head_ptr + 1'b1;
            end
            // push is never granted on a tick, so the new slot cannot collide with the scroll
            if (push) begin
                slots[tail_ptr] <= '{valid: 1'b1, y: '0};
                tail_ptr        <= tail_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mania_note_render.sv
// Pixel-data responder for vgac: renders a 4-lane falling-note playfield.
//   clk, rst            : clock, synchronous active-high reset
//   pix_ce              : pixel enable; d_in updates one pix_ce after row/col
//   row_addr, col_addr  : current vgac pixel; rdn=1 means blanking
//   d_in                : RGB444 pixel out
//   spawn_valid/lane    : new-note request, accepted when spawn_ready
//   key                 : lane keys (level); rising edges judge the lane head
//   hit_pulse/miss_pulse: one-cycle per-lane judgement pulses
//   score               : saturating hit count
// Build option: MANIA_AUTOPLAY_EN hits head notes automatically on frame ticks.
module mania_note_render
    import mania_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] d_in,
    input  logic        spawn_valid,
    input  logic [1:0]  spawn_lane,
    output logic        spawn_ready,
    input  logic [3:0]  key,
    output logic [3:0]  hit_pulse,
    output logic [3:0]  miss_pulse,
    output logic [15:0] score
);

    logic [8:0]       prev_row;
    logic             frame_tick;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] head_valid;
    logic [8:0]       head_y [LANES];
    logic [LANES-1:0] miss;
    logic [LANES-1:0] covered;
    logic [LANES-1:0] hit_req;
    logic [LANES-1:0] push;
    logic [LANES-1:0] tint;

    assign frame_tick  = pix_ce && (row_addr == '0) && (prev_row != '0);
    assign spawn_ready = !rst && !frame_tick && lane_ready[spawn_lane];

    always_ff @(posedge clk) begin
        if (rst)         prev_row <= '0;
        else if (pix_ce) prev_row <= row_addr;
    end

`ifdef MANIA_AUTOPLAY_EN
    logic [LANES-1:0] auto_tint;

    always_ff @(posedge clk) begin
        if (rst)             auto_tint <= '0;
        else if (frame_tick) auto_tint <= hit_req;
    end

    assign tint = auto_tint;
`else
    logic [LANES-1:0] key_q;
    logic [LANES-1:0] key_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= '0;
            key_prev <= '0;
        end else begin
            key_q    <= key;
            key_prev <= key_q;
        end
    end

    assign tint = key_q;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef MANIA_AUTOPLAY_EN
        assign hit_req[i] = frame_tick & head_valid[i] & autoplay_due(head_y[i]);
`else
        assign hit_req[i] = key_q[i] & ~key_prev[i] & head_valid[i] & in_hit_window(head_y[i]);
`endif
        assign push[i] = spawn_valid & spawn_ready & (spawn_lane == 2'(i));

        mania_lane_fifo u_fifo (
            .clk        (clk),
            .rst        (rst),
            .frame_tick (frame_tick),
            .push       (push[i]),
            .pop_hit    (hit_req[i]),
            .row        (row_addr),
            .ready      (lane_ready[i]),
            .head_valid (head_valid[i]),
            .head_y     (head_y[i]),
            .miss       (miss[i]),
            .covered    (covered[i])
        );
    end

    logic        in_lanes;
    logic [1:0]  lane_sel;
    logic [11:0] pix_val;
    logic [2:0]  hit_count;
    logic [16:0] score_sum;

    always_comb begin
        in_lanes = 1'b0;
        lane_sel = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if ((col_addr >= 10'(LANE_X0 + i * LANE_W)) &&
                (col_addr <  10'(LANE_X0 + (i + 1) * LANE_W))) begin
                in_lanes = 1'b1;
                lane_sel = 2'(i);
            end
        end
    end

    always_comb begin
        pix_val = COL_BG;
        if (!rdn && in_lanes) begin
            if (covered[lane_sel])
                pix_val = lane_colour(lane_sel);
            else if ((row_addr == 9'(HIT_ROW)) || (row_addr == 9'(HIT_ROW + 1)))
                pix_val = COL_HIT_LINE;
            else if (tint[lane_sel])
                pix_val = COL_TINT;
        end
    end

    always_comb begin
        hit_count = '0;
        for (int unsigned i = 0; i < LANES; i++) hit_count = hit_count + 3'(hit_req[i]);
        score_sum = {1'b0, score} + 17'(hit_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_in       <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            score      <= '0;
        end else begin
            if (pix_ce) d_in <= pix_val;
            hit_pulse  <= hit_req;
            miss_pulse <= miss;
            score      <= score_sum[16] ? '1 : score_sum[15:0];
        end
    end

endmodule

// File: tb/tb_mania_note_render.sv
// Scoreboard bench for mania_note_render: stimulus tasks update a lane-queue
// model and push expected pixels/judgement events; a forked monitor pops and
// compares whenever the DUT presents a pixel or a pulse.
module tb_mania_note_render;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_in;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        spawn_ready;
    logic [3:0]  key;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;
    logic [15:0] score;

    mania_note_render dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .rdn         (rdn),
        .d_in        (d_in),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .key         (key),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .score       (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [15:0] score;
    } ev_t;

    int          checks = 0;
    int          errors = 0;
    int          lane_q [4][$];
    bit          tint_m [4];
    int          m_score;
    logic [11:0] lane_col [4] = '{12'hF44, 12'h4F4, 12'h48F, 12'hFF4};
    logic [11:0] pix_exp [$];
    ev_t         ev_exp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_pix(input int row, input int col, input bit rd);
        int ln;
        if (rd) return 12'h000;
        if (col < 160 || col >= 480) return 12'h000;
        ln = (col - 160) / 80;
        for (int k = 0; k < lane_q[ln].size(); k++)
            if (row >= lane_q[ln][k] && row < lane_q[ln][k] + 16) return lane_col[ln];
        if (row == 420 || row == 421) return 12'hFFF;
        if (tint_m[ln]) return 12'h223;
        return 12'h000;
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < 4; l++) begin
            lane_q[l].delete();
            tint_m[l] = 1'b0;
        end
        m_score = 0;
    endfunction

    task automatic monitor();
        bit  pce_last = 1'b0;
        ev_t e;
        forever begin
            @(negedge clk);
            if (pce_last) begin
                if (pix_exp.size() == 0) chk("pixel_unexpected", 1, 0);
                else chk("d_in", d_in, pix_exp.pop_front());
            end
            pce_last = pix_ce;
            if ((hit_pulse | miss_pulse) != 4'b0) begin
                if (ev_exp.size() == 0) begin
                    chk("pulse_unexpected", {hit_pulse, miss_pulse}, 0);
                end else begin
                    e = ev_exp.pop_front();
                    chk("hit_pulse", hit_pulse, e.hit);
                    chk("miss_pulse", miss_pulse, e.miss);
                    chk("score_at_pulse", score, e.score);
                end
            end
        end
    endtask

    task automatic pix(input int row, input int col, input bit rd);
        pix_ce   = 1'b1;
        row_addr = 9'(row);
        col_addr = 10'(col);
        rdn      = rd;
        pix_exp.push_back(exp_pix(row, col, rd));
        @(posedge clk); #1;
        pix_ce = 1'b0;
    endtask

    task automatic frame(input bit try_spawn, input logic [1:0] sl);
        logic [3:0] mmask;
        ev_t        e;
        pix(1, 0, 1'b1);
        pix_ce   = 1'b1;
        row_addr = 9'd0;
        col_addr = 10'd0;
        rdn      = 1'b1;
        pix_exp.push_back(12'h000);
        if (try_spawn) begin
            spawn_valid = 1'b1;
            spawn_lane  = sl;
        end
        @(negedge clk);
        if (try_spawn) chk("spawn_ready_on_tick", spawn_ready, 0);
        @(posedge clk);
        mmask = 4'b0;
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < lane_q[l].size(); k++) lane_q[l][k] += 2;
            if (lane_q[l].size() > 0 && lane_q[l][0] >= 480) begin
                void'(lane_q[l].pop_front());
                mmask[l] = 1'b1;
            end
        end
        if (mmask != 4'b0) begin
            e.hit = 4'b0; e.miss = mmask; e.score = 16'(m_score);
            ev_exp.push_back(e);
        end
        #1;
        pix_ce      = 1'b0;
        spawn_valid = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 2'd0);
    endtask

    task automatic spawn(input logic [1:0] l);
        bit exp_rdy;
        spawn_valid = 1'b1;
        spawn_lane  = l;
        @(negedge clk);
        exp_rdy = lane_q[l].size() < 8;
        chk("spawn_ready", spawn_ready, exp_rdy);
        @(posedge clk);
        if (exp_rdy) lane_q[l].push_back(0);
        #1;
        spawn_valid = 1'b0;
    endtask

    task automatic press(input logic [1:0] l);
        ev_t e;
        int  c;
        key[l] = 1'b1;
        @(posedge clk); #1;
        tint_m[l] = 1'b1;
        @(posedge clk);
        if (lane_q[l].size() > 0) begin
            c = lane_q[l][0] + 8 - 420;
            if (c < 0) c = -c;
            if (c <= 24) begin
                void'(lane_q[l].pop_front());
                m_score = (m_score < 65535) ? m_score + 1 : 65535;
                e.hit = 4'b0001 << l; e.miss = 4'b0; e.score = 16'(m_score);
                ev_exp.push_back(e);
            end
        end
        #1;
        pix($urandom_range(1, 479), 160 + 80 * l + $urandom_range(0, 79), 1'b0);
        key[l] = 1'b0;
        @(posedge clk); #1;
        tint_m[l] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; pix_ce = 1'b0; row_addr = '0; col_addr = '0; rdn = 1'b1;
        spawn_valid = 1'b1; spawn_lane = 2'd0; key = 4'b0;
        model_reset();
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_spawn_ready", spawn_ready, 0);
        chk("reset_d_in", d_in, 0);
        chk("reset_score", score, 0);
        chk("reset_pulses", {hit_pulse, miss_pulse}, 0);
        @(posedge clk); #1;
        rst = 1'b0; spawn_valid = 1'b0;

        // notes in three lanes, then reset mid-frame
        spawn(2'd0); spawn(2'd1); spawn(2'd2);
        frames(5);
        pix(15, 200, 1'b0);
        pix(200, 300, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midreset_d_in", d_in, 0);
        chk("midreset_score", score, 0);
        @(posedge clk); #1;
        pix(15, 200, 1'b0);
        pix(15, 280, 1'b0);

        // single note to the judgement line and hit
        spawn(2'd1);
        frames(210);
        pix(425, 280, 1'b0);
        pix(425, 280, 1'b1);
        pix(420, 180, 1'b0);
        pix(421, 280, 1'b0);
        pix(300, 500, 1'b0);
        press(2'd1);
        pix(425, 280, 1'b0);

        // early key is ignored, then the note falls off as a miss
        spawn(2'd2);
        frames(150);
        press(2'd2);
        pix(305, 360, 1'b0);
        frames(90);
        pix(305, 360, 1'b0);

        // fill lane 0, overflow held, tick stalls spawn, pop frees a slot
        for (int i = 0; i < 9; i++) spawn(2'd0);
        frame(1'b1, 2'd3);
        frames(239);
        spawn(2'd0);
        frames(8);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      spawn(2'($urandom_range(0, 3)));
            else if (r <= 4) frames($urandom_range(1, 24));
            else if (r <= 7) pix($urandom_range(1, 479), $urandom_range(0, 639), $urandom_range(0, 7) == 0);
            else             press(2'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pending_events", ev_exp.size(), 0);
        chk("pending_pixels", pix_exp.size(), 0);
        chk("final_score", score, m_score);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
